// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction memory, and predicts taken control flow.
// Define FETCH_BHT_EN to build the direct-mapped BTB / 2-bit counter predictor; without it fetch is always PC+4.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        branchpredicted_o,
    input  logic        bp_update_i,
    input  logic [31:0] bp_update_pc_i,
    input  logic        bp_update_taken_i,
    input  logic [31:0] bp_update_target_i
);

    localparam int unsigned IDX   = $clog2(BHT_ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX - 2;

    typedef enum logic {ST_RST, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, npc;
    logic        valid_q, valid_d;
    logic        pred;
    logic [31:0] pred_target;
    logic        unused_bp;

`ifdef FETCH_BHT_EN
    logic [BHT_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BHT_ENTRIES];
    logic [31:0]            btb_target [BHT_ENTRIES];
    logic [1:0]             btb_ctr    [BHT_ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;

    assign lk_idx = fpc_q[IDX+1:2];
    assign lk_tag = fpc_q[31:IDX+2];
    assign up_idx = bp_update_pc_i[IDX+1:2];
    assign up_tag = bp_update_pc_i[31:IDX+2];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    // Lookup reads registered table contents, so a same-cycle update is seen only from the next cycle on.
    assign pred        = valid_q && btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag) && btb_ctr[lk_idx][1];
    assign pred_target = btb_target[lk_idx];
    assign unused_bp   = ^bp_update_pc_i[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btb_valid <= '0;
        end else if (bp_update_i && !up_hit && bp_update_taken_i) begin
            btb_valid[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && bp_update_i) begin
            if (up_hit) begin
                if (bp_update_taken_i) begin
                    btb_target[up_idx] <= bp_update_target_i;
                    if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                end
            end else if (bp_update_taken_i) begin
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= bp_update_target_i;
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end
`else
    assign pred        = 1'b0;
    assign pred_target = '0;
    assign unused_bp   = ^{bp_update_i, bp_update_pc_i, bp_update_taken_i, bp_update_target_i};
`endif

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        npc       = fpc_q;
        imem_en_o = 1'b1;
        case (state_q)
            ST_RST: begin
                imem_en_o = rst_n;
                npc       = RESET_PC;
                state_d   = ST_RUN;
                valid_d   = 1'b1;
            end
            ST_RUN: begin
                // Stall outranks redirect: decode operands are stale while the hazard holds.
                if (stall_i) begin
                    npc = fpc_q;
                end else if (redirect_i) begin
                    npc     = redirect_pc_i;
                    valid_d = 1'b1;
                end else if (pred) begin
                    npc     = pred_target;
                    valid_d = 1'b1;
                end else begin
                    npc     = fpc_q + 32'd4;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            fpc_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= npc;
            valid_q <= valid_d;
        end
    end

    assign imem_addr_o       = npc;
    assign pc_o              = fpc_q;
    assign inst_o            = valid_q ? imem_rdata_i : NOP_INST;
    assign branchpredicted_o = pred;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC, drives a synchronous instruction memory, and presents inst/pc/branchpredicted to decode.
- Predicts taken branches/jumps with a small direct-mapped BTB + 2-bit counter table.
- Accepts redirects (decode's pc_sel / branch target) and hazard stalls.

Parameters:
- RESET_PC, 32'h0000_0000, first instruction address after reset.
- BHT_ENTRIES, 16, predictor entries; power of 2, >=2. IDX = log2(BHT_ENTRIES).
- NOP_INST, 32'h0000_0013, instruction presented to decode when the slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous active-low.
- stall_i  in  1  hold PC and decode-side outputs (load-use hazard).
- redirect_i  in  1  decode redirect (decode pc_sel_out_o).
- redirect_pc_i  in  32  redirect target (decode pc_branch_target).
- imem_en_o  out  1  instruction memory read enable.
- imem_addr_o  out  32  instruction memory read address; memory registers the address, data valid next cycle.
- imem_rdata_i  in  32  instruction memory read data.
- inst_o  out  32  instruction to decode.
- pc_o  out  32  PC of inst_o.
- branchpredicted_o  out  1  fetch predicted inst_o taken and fetched its BTB target next.
- bp_update_i  in  1  resolved control-flow update strobe.
- bp_update_pc_i  in  32  PC of resolved branch/jump.
- bp_update_taken_i  in  1  resolved direction.
- bp_update_target_i  in  32  resolved taken target.

Behaviour:
- One clock. Reset is synchronous and active-low: any rising edge with rst_n=0 resets all state.
- State machine has 2 states:
  - RST, entered on reset: imem_en_o=rst_n, imem_addr_o=RESET_PC. At the next edge with rst_n=1 → RUN, fpc_q=RESET_PC, valid_q=1.
  - RUN: imem_en_o=1.
- Reset values:
  - state=RST, fpc_q=RESET_PC, valid_q=0, all BTB valid bits=0.
  - Outputs: inst_o=NOP_INST, pc_o=RESET_PC, branchpredicted_o=0, imem_en_o=0 while rst_n=0, imem_addr_o=RESET_PC.
- Output mapping:
  - pc_o=fpc_q.
  - inst_o = valid_q ? imem_rdata_i : NOP_INST.
- Prediction lookup (combinational, indexed by fpc_q):
  - idx=fpc_q[IDX+1:2], tag=fpc_q[31:IDX+2].
  - hit = entry.valid & tag match.
  - pred = valid_q & hit & ctr[1].
  - branchpredicted_o = pred.
- Next-PC in RUN, priority high→low:
  1. stall_i: npc=fpc_q. The same address is re-fetched; fpc_q, valid_q and outputs are held. redirect_i is ignored while stall_i=1, because decode operands are stale.
  2. redirect_i: npc=redirect_pc_i, valid_q←1.
  3. pred: npc=entry.target.
  4. else: npc=fpc_q+4, mod 2^32 (wraps 0xFFFF_FFFC→0).
- imem_addr_o=npc combinationally; fpc_q←npc at the edge.
- Zero-bubble timing: decode sees the redirect/predicted target instruction the cycle after.
- Redirect at 32'hxxxx_xxx2 (misaligned) is passed through unmodified; decode/exception logic owns that check.
- Predictor update on bp_update_i at the edge (index/tag from bp_update_pc_i):
  - Hit: ctr saturating +1 if taken, -1 if not (bounds 0..3). target←bp_update_target_i when taken.
  - Miss & taken: allocate: valid=1, tag, target, ctr=2'b10.
  - Miss & not taken: no change.
- Same-cycle lookup and update of one entry: lookup uses the pre-update value.
- Reset mid-operation: state→RST, valid_q=0, table cleared; any in-flight imem data is discarded (slot invalid → NOP).

Optional Feature:
- Macro: FETCH_BHT_EN.
- Defined: BTB/counter table present as above.
- Undefined:
  - No table storage.
  - branchpredicted_o tied 0.
  - Priority case 3 is removed (npc=fpc_q+4 unless stall/redirect).
  - bp_update_* ports are present but ignored.

Test Plan:
- Reset, release rst_n; memory returns 0x00500093 for address 0 → cycle 1 after release: imem_addr_o=0, en=1. Next: pc_o=0, inst_o=0x00500093, imem_addr_o=4. Then sequential 4, 8, 12.
- stall_i=1 for 3 cycles with pc_o=8 → pc_o stays 8, imem_addr_o=8, inst_o stable. Release → imem_addr_o=12 the same cycle.
- redirect_i=1, redirect_pc_i=0x100 at pc_o=0x10 → imem_addr_o=0x100 that cycle; next pc_o=0x100, valid. With stall_i=1 in the same cycle the redirect is ignored and pc_o stays 0x10.
- bp_update taken pc=0x20 target=0x80, then fetch reaches 0x20 (FETCH_BHT_EN) → branchpredicted_o=1, imem_addr_o=0x80. Two not-taken updates → ctr=0, no prediction, imem_addr_o=0x24.
- Counter saturation: 4 taken updates at 0x20 then 1 not-taken → ctr=2, still predicts taken. Aliasing PC 0x20+4·BHT_ENTRIES (0x60 for 16) → tag miss, no prediction.
- Assert rst_n=0 mid-run at pc_o=0x40 → next edge pc_o=RESET_PC, inst_o=NOP_INST, branchpredicted_o=0, previously trained PC 0x20 no longer predicts.
